// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one RAM data port between the core LSU (port 0) and
// the boot/debug loader (port 1) with round-robin priority and a bounded port-1 lock.
module mem_port_arbiter #(
  parameter int MAX_LOCK = 4,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [1:0]        req0_size,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [31:0]       req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [1:0]        req1_size,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [31:0]       req1_wdata,
  input  logic              req1_lock,
  output logic              resp0_valid,
  output logic [31:0]       resp0_rdata,
  output logic              resp0_err,
  output logic              resp1_valid,
  output logic [31:0]       resp1_rdata,
  output logic              resp1_err,
  output logic [1:0]        ram_write_en,
  output logic [1:0]        ram_read_en,
  output logic [ADDR_W-1:0] ram_data_addr,
  output logic [31:0]       ram_data_in,
  input  logic [31:0]       ram_data_out
);
  localparam int LOCK_W = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, ERROR} state_t;
  state_t state, state_next;

  logic              last_grant;
  logic [LOCK_W-1:0] lock_cnt;
  logic              cap_port;
  logic              cap_we;
  logic [1:0]        cap_size;
  logic [ADDR_W-1:0] cap_addr;
  logic [31:0]       cap_wdata;

  logic              grant0, grant1, accept, lock_ok;
  logic              sel_we, sel_bad;
  logic [1:0]        sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [31:0]       load_mask;

  assign lock_ok = req1_lock && (lock_cnt < LOCK_W'(MAX_LOCK));

  assign sel_we    = grant1 ? req1_we    : req0_we;
  assign sel_size  = grant1 ? req1_size  : req0_size;
  assign sel_addr  = grant1 ? req1_addr  : req0_addr;
  assign sel_wdata = grant1 ? req1_wdata : req0_wdata;
  assign sel_bad   = (sel_size == 2'b00)
                  || (sel_size == 2'b10 && sel_addr[0])
                  || (sel_size == 2'b11 && sel_addr[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Port 1 wins when alone, when it is its turn, or under an unexhausted lock.
  always_comb begin
    grant0     = 1'b0;
    grant1     = 1'b0;
    state_next = state;
    case (state)
      IDLE: begin
        if (req1_valid && (!req0_valid || !last_grant || lock_ok)) grant1 = 1'b1;
        else if (req0_valid)                                       grant0 = 1'b1;
        if (grant0 || grant1) state_next = sel_bad ? ERROR : ACCESS;
      end
      ACCESS:  state_next = IDLE;
      ERROR:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign accept     = grant0 || grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    case (cap_size)
      2'b01:   load_mask = 32'h0000_00ff;
      2'b10:   load_mask = 32'h0000_ffff;
      2'b11:   load_mask = 32'hffff_ffff;
      default: load_mask = '0;
    endcase
  end

  always_comb begin
    ram_write_en  = '0;
    ram_read_en   = '0;
    ram_data_addr = '0;
    ram_data_in   = '0;
    if (state == ACCESS) begin
      ram_data_addr = cap_addr;
      ram_data_in   = cap_wdata;
      if (cap_we) ram_write_en = cap_size;
      else        ram_read_en  = cap_size;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant  <= 1'b1;
      lock_cnt    <= '0;
      cap_port    <= 1'b0;
      cap_we      <= 1'b0;
      cap_size    <= '0;
      cap_addr    <= '0;
      cap_wdata   <= '0;
      resp0_valid <= 1'b0;
      resp0_err   <= 1'b0;
      resp0_rdata <= '0;
      resp1_valid <= 1'b0;
      resp1_err   <= 1'b0;
      resp1_rdata <= '0;
    end else begin
      resp0_valid <= 1'b0;
      resp0_err   <= 1'b0;
      resp0_rdata <= '0;
      resp1_valid <= 1'b0;
      resp1_err   <= 1'b0;
      resp1_rdata <= '0;
      if (accept) begin
        cap_port   <= grant1;
        cap_we     <= sel_we;
        cap_size   <= sel_size;
        cap_addr   <= sel_addr;
        cap_wdata  <= sel_wdata;
        last_grant <= grant1;
        // Lock only burns while port 0 is actually waiting.
        if (grant0 || !req1_lock)
          lock_cnt <= '0;
        else if (req0_valid && lock_cnt < LOCK_W'(MAX_LOCK))
          lock_cnt <= lock_cnt + 1'b1;
      end
      if (state == ACCESS || state == ERROR) begin
        if (cap_port) begin
          resp1_valid <= 1'b1;
          resp1_err   <= (state == ERROR);
          if (state == ACCESS && !cap_we) resp1_rdata <= ram_data_out & load_mask;
        end else begin
          resp0_valid <= 1'b1;
          resp0_err   <= (state == ERROR);
          if (state == ACCESS && !cap_we) resp0_rdata <= ram_data_out & load_mask;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: byte-array RAM, cycle-level reference
// model of the arbitration rules, directed scenarios and randomized traffic.
module tb_mem_port_arbiter;
  localparam int MAX_LOCK = 4;
  localparam int ADDR_W   = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_valid, req0_ready, req0_we;
  logic [1:0]        req0_size;
  logic [ADDR_W-1:0] req0_addr;
  logic [31:0]       req0_wdata;
  logic              req1_valid, req1_ready, req1_we, req1_lock;
  logic [1:0]        req1_size;
  logic [ADDR_W-1:0] req1_addr;
  logic [31:0]       req1_wdata;
  logic              resp0_valid, resp0_err, resp1_valid, resp1_err;
  logic [31:0]       resp0_rdata, resp1_rdata;
  logic [1:0]        ram_write_en, ram_read_en;
  logic [ADDR_W-1:0] ram_data_addr;
  logic [31:0]       ram_data_in, ram_data_out;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_LOCK(MAX_LOCK), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_size(req0_size), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_size(req1_size), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_lock(req1_lock),
    .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata), .resp0_err(resp0_err),
    .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata), .resp1_err(resp1_err),
    .ram_write_en(ram_write_en), .ram_read_en(ram_read_en),
    .ram_data_addr(ram_data_addr), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out)
  );

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b01) ? 1 : (s == 2'b10) ? 2 : (s == 2'b11) ? 4 : 0;
  endfunction

  function automatic logic [11:0] ba(input logic [ADDR_W-1:0] a, input int i);
    return 12'(int'(a[11:0]) + i);
  endfunction

  // RAM seen by the DUT: little-endian bytes, right-aligned combinational read.
  bit [7:0] ram_mem [4096];
  bit [7:0] ref_mem [4096];

  always_comb begin
    ram_data_out = '0;
    for (int i = 0; i < 4; i++)
      if (i < nbytes(ram_read_en)) ram_data_out[8*i +: 8] = ram_mem[ba(ram_data_addr, i)];
  end

  always @(posedge clk)
    if (ram_write_en != 2'b00)
      for (int i = 0; i < nbytes(ram_write_en); i++)
        ram_mem[ba(ram_data_addr, i)] <= ram_data_in[8*i +: 8];

  function automatic logic [31:0] ram_word(input logic [ADDR_W-1:0] a);
    return {ram_mem[ba(a, 3)], ram_mem[ba(a, 2)], ram_mem[ba(a, 1)], ram_mem[ba(a, 0)]};
  endfunction

  int n_pass = 0;
  int n_total = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: free/serving flag, turn holder, lock usage, pending response.
  int                m_busy, m_last, m_lock, m_port, acc_port;
  logic              m_we, m_bad, e_err;
  logic [1:0]        m_size, e_rv;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_wdata, e_rdata;
  logic [31:0]       last_rdata [2];
  logic              last_err [2];
  int                grant_log [$];

  task automatic model_reset();
    m_busy = 0; m_last = 1; m_lock = 0; acc_port = -1;
    e_rv = '0; e_err = 1'b0; e_rdata = '0;
  endtask

  // Called just after a negedge with inputs set; checks this cycle, advances to the next negedge.
  task automatic step();
    int win;
    logic [1:0] exp_we, exp_re;
    logic [31:0] got_rdata;
    logic got_err;
    #1;
    win = -1;
    if (m_busy == 0) begin
      if (req0_valid && !req1_valid)      win = 0;
      else if (req1_valid && !req0_valid) win = 1;
      else if (req0_valid && req1_valid) begin
        if (m_last == 1 && req1_lock && m_lock < MAX_LOCK) win = 1;
        else win = 1 - m_last;
      end
    end
    check_eq("req0_ready", {31'b0, req0_ready}, {31'b0, win == 0});
    check_eq("req1_ready", {31'b0, req1_ready}, {31'b0, win == 1});
    check_eq("resp0_valid", {31'b0, resp0_valid}, {31'b0, e_rv[0]});
    check_eq("resp1_valid", {31'b0, resp1_valid}, {31'b0, e_rv[1]});
    for (int p = 0; p < 2; p++) begin
      if (e_rv[p]) begin
        got_rdata = (p == 0) ? resp0_rdata : resp1_rdata;
        got_err   = (p == 0) ? resp0_err   : resp1_err;
        check_eq("resp_err", {31'b0, got_err}, {31'b0, e_err});
        check_eq("resp_rdata", got_rdata, e_rdata);
        last_rdata[p] = got_rdata;
        last_err[p]   = got_err;
      end
    end
    exp_we = (m_busy == 1 && !m_bad &&  m_we) ? m_size : 2'b00;
    exp_re = (m_busy == 1 && !m_bad && !m_we) ? m_size : 2'b00;
    check_eq("ram_write_en", {30'b0, ram_write_en}, {30'b0, exp_we});
    check_eq("ram_read_en", {30'b0, ram_read_en}, {30'b0, exp_re});
    if (m_busy == 1 && !m_bad) begin
      check_eq("ram_data_addr", ram_data_addr, m_addr);
      if (m_we) check_eq("ram_data_in", ram_data_in, m_wdata);
    end
    e_rv = '0; e_err = 1'b0; e_rdata = '0; acc_port = -1;
    if (m_busy == 1) begin
      e_rv[m_port] = 1'b1;
      e_err = m_bad;
      if (!m_bad)
        for (int i = 0; i < nbytes(m_size); i++)
          if (m_we) ref_mem[ba(m_addr, i)] = m_wdata[8*i +: 8];
          else      e_rdata[8*i +: 8] = ref_mem[ba(m_addr, i)];
      m_busy = 0;
    end else if (win >= 0) begin
      m_port  = win;
      m_we    = (win == 0) ? req0_we    : req1_we;
      m_size  = (win == 0) ? req0_size  : req1_size;
      m_addr  = (win == 0) ? req0_addr  : req1_addr;
      m_wdata = (win == 0) ? req0_wdata : req1_wdata;
      m_bad   = (m_size == 2'b00) || (m_size == 2'b10 && m_addr[0] != 1'b0)
             || (m_size == 2'b11 && m_addr[1:0] != 2'b00);
      if (win == 0 || !req1_lock)             m_lock = 0;
      else if (req0_valid && m_lock < MAX_LOCK) m_lock++;
      m_last = win; m_busy = 1; acc_port = win;
      grant_log.push_back(win);
    end
    @(negedge clk);
  endtask

  task automatic drive(input int p, input logic v, input logic we, input logic [1:0] sz,
                       input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic lk);
    if (p == 0) begin
      req0_valid = v; req0_we = we; req0_size = sz; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = v; req1_we = we; req1_size = sz; req1_addr = a; req1_wdata = d; req1_lock = lk;
    end
  endtask

  task automatic issue(input int p, input logic we, input logic [1:0] sz,
                       input logic [ADDR_W-1:0] a, input logic [31:0] d);
    int budget;
    budget = 50;
    drive(p, 1'b1, we, sz, a, d, 1'b0);
    acc_port = -1;
    while (acc_port != p && budget > 0) begin step(); budget--; end
    if (acc_port != p) check_eq("accept_timeout", 32'd0, 32'd1);
    drive(p, 1'b0, 1'b0, 2'b00, '0, '0, 1'b0);
    step();
    step();
  endtask

  task automatic run_grants(input int k);
    int budget;
    budget = 100;
    while (grant_log.size() < k && budget > 0) begin step(); budget--; end
    if (grant_log.size() < k) check_eq("grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic randomize_port(input int p);
    logic [ADDR_W-1:0] a;
    a = ADDR_W'({$urandom_range(0, 1023), 2'b00});
    if ($urandom_range(0, 3) == 0) a = a + ADDR_W'($urandom_range(1, 3));
    drive(p, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          a, $urandom, 1'($urandom_range(0, 1)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int exp_pat [7];
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 2'b00, '0, '0, 1'b0);
    drive(1, 1'b0, 1'b0, 2'b00, '0, '0, 1'b0);
    model_reset();
    @(negedge clk);
    check_eq("rst_resp0_valid", {31'b0, resp0_valid}, 32'd0);
    check_eq("rst_resp1_valid", {31'b0, resp1_valid}, 32'd0);
    check_eq("rst_rdata0", resp0_rdata, 32'd0);
    check_eq("rst_write_en", {30'b0, ram_write_en}, 32'd0);
    check_eq("rst_read_en", {30'b0, ram_read_en}, 32'd0);
    check_eq("rst_addr", ram_data_addr, 32'd0);
    check_eq("rst_data_in", ram_data_in, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    issue(0, 1'b1, 2'b11, 32'hf0, 32'h00ff00ff);
    issue(0, 1'b0, 2'b11, 32'hf0, 32'h0);
    check_eq("load_word_f0", last_rdata[0], 32'h00ff00ff);
    issue(0, 1'b1, 2'b10, 32'hf2, 32'h1222);
    issue(0, 1'b0, 2'b01, 32'hf3, 32'h0);
    check_eq("load_byte_f3", last_rdata[0], 32'h12);
    issue(0, 1'b0, 2'b11, 32'hf0, 32'h0);
    check_eq("load_word_merged", last_rdata[0], 32'h122200ff);

    issue(0, 1'b1, 2'b11, 32'hf2, 32'hffffffff);
    check_eq("err_word_misalign", {31'b0, last_err[0]}, 32'd1);
    issue(0, 1'b0, 2'b10, 32'hf1, 32'h0);
    check_eq("err_half_misalign", {31'b0, last_err[0]}, 32'd1);
    issue(0, 1'b0, 2'b00, 32'hf0, 32'h0);
    check_eq("err_size0", {31'b0, last_err[0]}, 32'd1);
    check_eq("err_rdata", last_rdata[0], 32'd0);
    check_eq("err_ram_untouched", ram_word(32'hf0), 32'h122200ff);

    issue(0, 1'b1, 2'b11, 32'hab0, 32'h000ababa);
    drive(0, 1'b1, 1'b1, 2'b11, 32'hab0, 32'h0000dead, 1'b0);
    run_grants(grant_log.size() + 1);
    rst = 1'b1;
    #1;
    check_eq("midrst_write_en", {30'b0, ram_write_en}, 32'd0);
    check_eq("midrst_read_en", {30'b0, ram_read_en}, 32'd0);
    @(negedge clk);
    check_eq("midrst_no_resp", {31'b0, resp0_valid}, 32'd0);
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 2'b00, '0, '0, 1'b0);
    model_reset();
    check_eq("midrst_ram_kept", ram_word(32'hab0), 32'h000ababa);

    grant_log.delete();
    drive(0, 1'b1, 1'b0, 2'b11, 32'hf0, 32'h0, 1'b0);
    drive(1, 1'b1, 1'b0, 2'b11, 32'hf00, 32'h0, 1'b0);
    run_grants(4);
    exp_pat = '{0, 1, 0, 1, 0, 0, 0};
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check_eq("contention_order", 32'(grant_log[i]), 32'(exp_pat[i]));
    drive(0, 1'b0, 1'b0, 2'b00, '0, '0, 1'b0);
    drive(1, 1'b0, 1'b0, 2'b00, '0, '0, 1'b0);
    step(); step(); step();

    grant_log.delete();
    drive(1, 1'b1, 1'b0, 2'b11, 32'hf00, 32'h0, 1'b1);
    run_grants(1);
    drive(0, 1'b1, 1'b0, 2'b11, 32'hf0, 32'h0, 1'b0);
    run_grants(7);
    exp_pat = '{1, 1, 1, 1, 1, 0, 1};
    for (int i = 0; i < 7 && i < grant_log.size(); i++)
      check_eq("lock_order", 32'(grant_log[i]), 32'(exp_pat[i]));
    drive(0, 1'b0, 1'b0, 2'b00, '0, '0, 1'b0);
    drive(1, 1'b0, 1'b0, 2'b00, '0, '0, 1'b0);
    step(); step(); step();

    for (int n = 0; n < 400; n++) begin
      if (!req0_valid || acc_port == 0) randomize_port(0);
      if (!req1_valid || acc_port == 1) randomize_port(1);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the RAM data port between two requesters: port 0 is the core load/store unit, port 1 is the boot/debug loader.
- Uses a valid/ready request handshake and a registered response.
- Selects between the two ports with round-robin priority. Port 1 has a bounded lock option for burst loading.
- Checks alignment and drives the RAM size-encoded enables: 00 none, 01 byte, 10 half, 11 word.

Parameters:
- MAX_LOCK, 4, maximum consecutive locked grants to port 1 while port 0 is pending (must be ≥1).
- ADDR_W, 32, request and RAM address width.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- reqN_valid  in  1  request valid (N = 0, 1).
- reqN_ready  out  1  request accepted this cycle.
- reqN_we  in  1  1 = store, 0 = load.
- reqN_size  in  2  00 invalid, 01 byte, 10 half, 11 word.
- reqN_addr  in  ADDR_W  byte address.
- reqN_wdata  in  32  store data, right-aligned.
- req1_lock  in  1  port 1 requests retained priority.
- respN_valid  out  1  one-cycle response pulse.
- respN_rdata  out  32  load data, zero-extended; 0 for stores and errors.
- respN_err  out  1  misaligned or invalid-size request, qualified by respN_valid.
- ram_write_en  out  2  to RAM write_en.
- ram_read_en  out  2  to RAM read_en.
- ram_data_addr  out  ADDR_W  to RAM data_addr.
- ram_data_in  out  32  to RAM data_in.
- ram_data_out  in  32  from RAM, combinational read.

Behaviour:
- Reset:
  - state IDLE, last_grant = 1 (port 0 wins the first tie), lock_cnt = 0.
  - All ready/resp_valid/err = 0, rdata = 0, ram enables = 00, ram addr/data = 0.
- FSM IDLE:
  - reqN_ready is combinational and goes to exactly one winner when any valid is high.
  - The request is captured at the edge where valid & ready. Next state is ACCESS, or ERROR if the request is illegal.
- Illegal request:
  - size 00, half with addr[0] = 1, or word with addr[1:0] ≠ 00.
- FSM ACCESS, one cycle:
  - Drive the captured addr and wdata.
  - Store: ram_write_en = size, ram_read_en = 00. Load: ram_read_en = size, ram_write_en = 00.
  - At the closing edge: the store commits in RAM, and for a load ram_data_out is registered into respN_rdata.
  - Next state IDLE.
- FSM ERROR, one cycle:
  - RAM enables stay 00 and the RAM is untouched. Next state IDLE.
- Response timing:
  - respN_valid is high for exactly the cycle after ACCESS/ERROR, on the granted port only. respN_err is set in that cycle for ERROR.
  - resp_valid overlaps the IDLE cycle, so a new request may be accepted in that same cycle.
  - Latency from accept edge to resp_valid is 2 cycles. Peak throughput is one request per 2 cycles.
- RAM enables are 00 in every state except ACCESS.
- Arbitration, evaluated in IDLE:
  - Only one valid: that port wins.
  - Both valid: the port ≠ last_grant wins, except for the lock override.
  - Lock override: port 1 wins when last_grant = 1, req1_lock = 1 and lock_cnt < MAX_LOCK.
  - last_grant updates on every accept.
- lock_cnt:
  - Increments on each port-1 accept made while req0_valid = 1 (saturating).
  - Clears on any port-0 accept, and on any port-1 accept with req1_lock = 0.
  - Port 1 alone, with port 0 idle, never exhausts the lock.
- ready deasserts outside IDLE. Requesters must hold valid and payload stable until ready; the arbiter does not check this.
- Reset asserted mid-ACCESS:
  - Enables drop to 00 immediately (asynchronous). A store not yet clocked is not committed.
  - No response pulse is issued. The FSM restarts in IDLE.

Test Plan:
- Store then load, port 0: word store 0xff00ff at 0xf0, then word load 0xf0 → resp0_valid 2 cycles after each accept; load resp0_rdata = 0x00ff00ff, err 0; ram_write_en = 11 for exactly one cycle.
- Sub-word access: half store 0x1222 at 0xf2 over 0x00ff00ff, then byte load 0xf3 → rdata 0x12; word load 0xf0 → 0x122200ff.
- Contention after reset: both ports valid word loads at 0xf0 / 0xf00 → port 0 accepted first, port 1 on the next IDLE cycle; grants alternate 0, 1, 0, 1 while both are held valid.
- Lock bound (MAX_LOCK = 4): port 1 granted with req1_lock = 1 held, then req0_valid rises → exactly 4 further port-1 grants, then port 0 granted, then port 1 again.
- Misaligned/invalid: port 0 word store at 0xf2, half load at 0xf1, size 00 → each gives resp0_err = 1, rdata 0, ram enables 00 throughout, and RAM word at 0xf0 unchanged.
- Reset mid-ACCESS of a word store 0xdead at 0xab0 (RAM previously 0xababa) → enables 00 at once, no resp pulse, RAM still 0xababa; first grant after reset goes to port 0.
